// File: rtl/reflex_const_packer.sv
// reflex_const_packer
// Writer side of the reflex gate's 64-bit packed constant word. Host writes
// land in range-checked shadow registers; a commit request validates the
// whole shadow set and transfers it atomically into the live word, so the
// reflex kernel never observes a torn or illegal constant.
//
// Optional build macro: REFLEX_CONST_READBACK_EN
//   adds rb_addr/rb_data (registered shadow readback) and dirty_mask.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting field writes and commit requests (cfg_ready=1)
// CHECK | validating shadow set; verdict latched on first edge, acted on
//       | at the second edge (down-counter reaches terminal count)
// APPLY | shadow set copied to live word at exit, commit_done pulses
// FAIL  | live word untouched, commit_err pulsing, returns to IDLE

module reflex_const_packer #(
   parameter int ALPHA_BITS   = 4,
   parameter int PI_ECHO_BITS = 28,
   parameter int CONST_WIDTH  = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [2:0]             cfg_addr,
   input  logic [31:0]            cfg_data,
   input  logic                   commit_req,
   output logic [CONST_WIDTH-1:0] packed_const,
   output logic                   const_valid,
   output logic                   cfg_err,
   output logic                   commit_done,
`ifdef REFLEX_CONST_READBACK_EN
   input  logic [2:0]             rb_addr,
   output logic [31:0]            rb_data,
   output logic [4:0]             dirty_mask,
`endif
   output logic                   commit_err
);

   // the packed layout is only defined for a 64-bit word
   generate
      if (CONST_WIDTH != 64) begin : g_width_check
         $error("reflex_const_packer: CONST_WIDTH must be 64");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      APPLY = 2'd2,
      FAIL  = 2'd3
   } state_t;

   // CHECK lasts two cycles: verdict latched, then acted upon
   localparam logic [1:0] CHK_LOAD = 2'd1;

   state_t r_state;
   state_t w_next;

   logic [ALPHA_BITS-1:0]   r_sh_alpha;
   logic [PI_ECHO_BITS-1:0] r_sh_pie;
   logic [15:0]             r_sh_pit;
   logic [7:0]              r_sh_ephase;
   logic [7:0]              r_sh_etime;
   logic [4:0]              r_written;
   logic [4:0]              r_dirty;

   logic [CONST_WIDTH-1:0]  r_live;
   logic                    r_const_valid;
   logic                    r_cfg_err;
   logic                    r_commit_done;
   logic                    r_commit_err;
   logic [1:0]              r_chk_cnt;
   logic                    r_chk_fail;

   logic                    w_idle;
   logic                    w_wr_acc;
   logic                    w_legal;
   logic                    w_wr_ok;
   logic                    w_commit_acc;
   logic                    w_chk_tc;
   logic                    w_chk_fail_now;
   logic [ALPHA_BITS-1:0]   w_alpha_st;
   logic [4:0]              w_field_sel;
   logic [CONST_WIDTH-1:0]  w_shadow_word;

   assign w_idle       = (r_state == IDLE);
   assign cfg_ready    = w_idle & ~rst;
   assign w_wr_acc     = cfg_valid & w_idle;
   assign w_wr_ok      = w_wr_acc & w_legal;
   assign w_commit_acc = commit_req & w_idle;
   assign w_chk_tc     = (r_chk_cnt == 2'd0);
   assign w_alpha_st   = cfg_data[ALPHA_BITS-1:0] - {{(ALPHA_BITS-1){1'b0}}, 1'b1};

   assign w_chk_fail_now = (r_written != 5'b11111) ||
      ({{(PI_ECHO_BITS-8){1'b0}}, r_sh_etime} >= r_sh_pie);

   assign w_shadow_word = {r_sh_alpha, r_sh_pie, r_sh_pit, r_sh_ephase, r_sh_etime};

   // field legality and one-hot field select for the incoming write
   always_comb begin
      w_legal     = 1'b0;
      w_field_sel = 5'b00000;
      case (cfg_addr)
         3'd0: begin
            w_legal     = (cfg_data >= 32'd1) && (cfg_data <= (32'd1 << ALPHA_BITS));
            w_field_sel = 5'b00001;
         end
         3'd1: begin
            w_legal     = (cfg_data[31:PI_ECHO_BITS] == '0) && (cfg_data != 32'd0);
            w_field_sel = 5'b00010;
         end
         3'd2: begin
            w_legal     = (cfg_data[31:16] == 16'd0);
            w_field_sel = 5'b00100;
         end
         3'd3: begin
            w_legal     = (cfg_data[31:8] == 24'd0);
            w_field_sel = 5'b01000;
         end
         3'd4: begin
            w_legal     = (cfg_data[31:8] == 24'd0);
            w_field_sel = 5'b10000;
         end
         default: begin
            w_legal     = 1'b0;
            w_field_sel = 5'b00000;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_commit_acc) w_next = CHECK;
         CHECK:   if (w_chk_tc) w_next = r_chk_fail ? FAIL : APPLY;
         APPLY:   w_next = IDLE;
         FAIL:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // shadow registers and written/dirty masks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_alpha  <= '0;
         r_sh_pie    <= '0;
         r_sh_pit    <= '0;
         r_sh_ephase <= '0;
         r_sh_etime  <= '0;
         r_written   <= '0;
         r_dirty     <= '0;
      end else begin
         if (w_wr_ok) begin
            case (cfg_addr)
               3'd0:    r_sh_alpha  <= w_alpha_st;
               3'd1:    r_sh_pie    <= cfg_data[PI_ECHO_BITS-1:0];
               3'd2:    r_sh_pit    <= cfg_data[15:0];
               3'd3:    r_sh_ephase <= cfg_data[7:0];
               3'd4:    r_sh_etime  <= cfg_data[7:0];
               default: ;
            endcase
            r_written <= r_written | w_field_sel;
         end
         if (r_state == APPLY)
            r_dirty <= '0;
         else if (w_wr_ok)
            r_dirty <= r_dirty | w_field_sel;
      end
   end

   // check timer: loaded on commit acceptance, verdict latched on first CHECK edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chk_cnt  <= '0;
         r_chk_fail <= 1'b0;
      end else if (w_commit_acc) begin
         r_chk_cnt  <= CHK_LOAD;
         r_chk_fail <= 1'b0;
      end else if (r_state == CHECK && !w_chk_tc) begin
         r_chk_cnt  <= r_chk_cnt - 2'd1;
         r_chk_fail <= w_chk_fail_now;
      end
   end

   // live word, status flag and one-cycle result pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_live        <= '0;
         r_const_valid <= 1'b0;
         r_cfg_err     <= 1'b0;
         r_commit_done <= 1'b0;
         r_commit_err  <= 1'b0;
      end else begin
         r_cfg_err     <= w_wr_acc & ~w_legal;
         r_commit_done <= (r_state == APPLY);
         r_commit_err  <= (r_state == CHECK) && w_chk_tc && r_chk_fail;
         if (r_state == APPLY) begin
            r_live        <= w_shadow_word;
            r_const_valid <= 1'b1;
         end
      end
   end

   assign packed_const = r_live;
   assign const_valid  = r_const_valid;
   assign cfg_err      = r_cfg_err;
   assign commit_done  = r_commit_done;
   assign commit_err   = r_commit_err;

`ifdef REFLEX_CONST_READBACK_EN
   logic [31:0] r_rb_data;

   // registered readback of the selected shadow; alpha shown unscaled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rb_data <= '0;
      end else begin
         case (rb_addr)
            3'd0:    r_rb_data <= {{(32-ALPHA_BITS){1'b0}}, r_sh_alpha} + 32'd1;
            3'd1:    r_rb_data <= {{(32-PI_ECHO_BITS){1'b0}}, r_sh_pie};
            3'd2:    r_rb_data <= {16'd0, r_sh_pit};
            3'd3:    r_rb_data <= {24'd0, r_sh_ephase};
            3'd4:    r_rb_data <= {24'd0, r_sh_etime};
            default: r_rb_data <= '0;
         endcase
      end
   end

   assign rb_data    = r_rb_data;
   assign dirty_mask = r_dirty;
`endif

endmodule

// File: doc/reflex_const_packer.md
Name: reflex_const_packer

Overview:
Writer side of the reflex gate's 64-bit packed constant word. Accepts per-field configuration writes over a valid/ready bus into shadow registers, range-checks each field, and atomically commits the shadow set into the live packed_const word on request. It sits between the host/config fabric and the integer-gate reflex kernel, so the kernel never sees a torn or illegal constant (e.g. zero π_echo modulus).

Parameters:
ALPHA_BITS, 4, width of α₀ nibble (stored as α₀-1).
PI_ECHO_BITS, 28, width of π_echo★ field (×1e-6).
CONST_WIDTH, 64, width of packed output word; fixed at 64, elaboration error otherwise.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cfg_valid  in  1  field write request
cfg_ready  out  1  packer can accept a write or commit
cfg_addr  in  3  field select: 0=α₀, 1=π_echo, 2=π_T, 3=ε_phase, 4=ε_time
cfg_data  in  32  raw field value (unscaled α₀, or integer-scaled value)
commit_req  in  1  request atomic transfer of shadow set to live word
packed_const  out  64  live constant: [63:60] α₀-1, [59:32] π_echo, [31:16] π_T, [15:8] ε_phase, [7:0] ε_time
const_valid  out  1  live word has been committed at least once
cfg_err  out  1  one-cycle pulse: write rejected
commit_done  out  1  one-cycle pulse: commit applied
commit_err  out  1  one-cycle pulse: commit rejected

Behaviour:
- Reset: all outputs 0 except cfg_ready=1 once rst deasserts. State IDLE. Shadows are 0, written_mask=0, dirty_mask=0. Reset mid-commit aborts the commit; the live word returns to 0.
- FSM: IDLE -> CHECK -> (APPLY | FAIL) -> IDLE. cfg_ready=1 only in IDLE.
- Write handshake: a write is accepted on cfg_valid & cfg_ready.
  - Legal write updates that field's shadow at the next edge and sets its written and dirty bits.
  - cfg_err pulses the cycle after an illegal write; the shadow and masks are unchanged.
- Legality rules:
  - addr 0: data in 1..16, stored as data-1.
  - addr 1: data in 1..2^28-1; data[31:28] must be 0; zero is rejected.
  - addr 2: data[31:16] must be 0.
  - addr 3/4: data[31:8] must be 0.
  - addr 5..7: always illegal.
- Commit: commit_req is sampled only in IDLE; it is ignored while busy (no queuing).
  - Write and commit_req accepted in the same cycle: the write lands first and is included in the commit.
- CHECK (one cycle after acceptance, edge T+1), fails if either holds:
  - written_mask != 5'b11111, or
  - shadow ε_time >= shadow π_echo (tolerance must be below the period).
- APPLY: packed_const and const_valid update, dirty_mask clears, commit_done=1. All of these are visible from edge T+3. Commit latency is 3 cycles from acceptance.
- FAIL: commit_err=1 from edge T+2 for one cycle; the live word is unchanged; the state returns to IDLE.
- Commit with dirty_mask=0 and all checks passing: still APPLY with commit_done; the live word value is unchanged.
- The live word changes only in APPLY. It never reflects a partial shadow set.

Optional Feature:
REFLEX_CONST_READBACK_EN
- Defined: adds input rb_addr[2:0] and output rb_data[31:0].
  - rb_data is a registered (1-cycle) readback of the selected shadow field, zero-extended.
  - α₀ is returned as stored+1; addr 5..7 return 0.
  - Adds output dirty_mask[4:0].
- Undefined: none of these ports or registers exist. Core behaviour is identical.

Test Plan:
- Write α₀=4, π_echo=1000, π_T=9000, ε_phase=50, ε_time=20, then commit_req -> commit_done at T+3, packed_const=64'h300003E8_23283214, const_valid=1.
- Write α₀=0, α₀=17, π_echo=0, addr 6 -> cfg_err pulse after each. Then complete the legal set and commit -> packed_const matches the legal values only.
- After reset, write only α₀ and π_echo, then commit -> commit_err at T+2, packed_const=0, const_valid=0.
- Live word as in test 1; write ε_time=250, π_echo=200, commit -> commit_err. Then write π_echo=300, commit -> commit_done and packed_const[59:32]=300, [7:0]=250.
- Assert commit_req with cfg_valid (addr 3, data 77) in the same IDLE cycle -> committed word has [15:8]=77. Second commit_req during CHECK is ignored; exactly one commit_done.
- Assert rst at T+2 of a commit -> all outputs 0 asynchronously. After release, commit_req -> commit_err because written_mask was cleared.
